// File: rtl/ttl_counter_bank.sv
// ttl_counter_bank: bank of up/down counters with per-channel clear/load, optional cascade into one wide counter, and combinational terminal count
module ttl_counter_bank #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 4
) (
    input  logic                      CLK,
    input  logic                      R,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       UP,
    input  logic [CHANNELS-1:0]       CLR,
    input  logic [CHANNELS-1:0]       LOAD,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic                      CASCADE,
    input  logic                      VCC,
    input  logic                      GND,
    output logic [CHANNELS*WIDTH-1:0] O,
    output logic [CHANNELS-1:0]       TC
);
    logic [CHANNELS*WIDTH-1:0] nxt;
    logic [CHANNELS-1:0]       ce;
    logic [WIDTH-1:0]          cnt;
    logic                      c;
    logic                      unused_pwr;
    assign unused_pwr = VCC ^ GND;
    always_comb begin
        nxt = '0;
        ce  = '0;
        TC  = '0;
        cnt = '0;
        c   = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt   = O[i*WIDTH +: WIDTH];
            ce[i] = EN[i] & (c | ~CASCADE);
            TC[i] = ce[i] & (UP[i] ? &cnt : ~|cnt);
            c     = TC[i];
            nxt[i*WIDTH +: WIDTH] = CLR[i]  ? '0 :
                                    LOAD[i] ? D[i*WIDTH +: WIDTH] :
                                    ce[i]   ? (UP[i] ? cnt + 1'b1 : cnt - 1'b1) : cnt;
        end
    end
    always_ff @(posedge CLK or posedge R)
        if (R) O <= '0;
        else   O <= nxt;
endmodule
